// File: rtl/matrix_loader.sv
// Streams operands X then Y into the multiplier's operand RAMs, clamping each X element.
// Then it starts the multiplier, waits for busy to fall, and pulses done.
module matrix_loader #(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int X_ROWS        = 5,
   parameter int Y_COLS        = 5,
   parameter int X_COLS_Y_ROWS = 5,
   parameter int X_MAX         = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [ADDR_WIDTH-1:0] x_wr_addr,
   output logic [DATA_WIDTH-1:0] x_wr_data,
   output logic                  x_wr_en,
   output logic [ADDR_WIDTH-1:0] y_wr_addr,
   output logic [DATA_WIDTH-1:0] y_wr_data,
   output logic                  y_wr_en,
   output logic                  mm_start,
   input  logic                  mm_busy,
   output logic                  done,
   output logic                  err_range,
   output logic                  active
);

   localparam int NX = X_ROWS * X_COLS_Y_ROWS;
   localparam int NY = X_COLS_Y_ROWS * Y_COLS;
   localparam logic [ADDR_WIDTH-1:0] LAST_X  = ADDR_WIDTH'(NX - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_Y  = ADDR_WIDTH'(NY - 1);
   localparam logic [DATA_WIDTH-1:0] X_MAX_W = DATA_WIDTH'(X_MAX);

   typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, START, WAIT_DONE, FINISH} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] cnt;
   logic                  beat;
   logic                  clamp;

   assign beat  = s_valid & s_ready;
   assign clamp = (s_data > X_MAX_W);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      mm_start  = 1'b0;
      done      = 1'b0;
      active    = 1'b1;
      case (state)
         IDLE: begin
            active = 1'b0;
            if (load) state_nxt = LOAD_X;
         end
         LOAD_X: begin
            s_ready = 1'b1;
            if (beat && cnt == LAST_X) state_nxt = LOAD_Y;
         end
         LOAD_Y: begin
            s_ready = 1'b1;
            if (beat && cnt == LAST_Y) state_nxt = START;
         end
         START: begin
            mm_start = 1'b1;
            if (mm_busy) state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!mm_busy) state_nxt = FINISH;
         end
         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // One counter serves as both element count and write address for each operand in turn.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         err_range <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  cnt       <= '0;
                  err_range <= 1'b0;
               end
            end
            LOAD_X: begin
               if (beat) begin
                  cnt <= (cnt == LAST_X) ? '0 : cnt + 1'b1;
                  if (clamp) err_range <= 1'b1;
               end
            end
            LOAD_Y: begin
               if (beat) cnt <= (cnt == LAST_Y) ? '0 : cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_wr_en   <= 1'b0;
         x_wr_addr <= '0;
         x_wr_data <= '0;
         y_wr_en   <= 1'b0;
         y_wr_addr <= '0;
         y_wr_data <= '0;
      end else begin
         x_wr_en <= beat && (state == LOAD_X);
         y_wr_en <= beat && (state == LOAD_Y);
         if (beat && state == LOAD_X) begin
            x_wr_addr <= cnt;
            x_wr_data <= clamp ? X_MAX_W : s_data;
         end
         if (beat && state == LOAD_Y) begin
            y_wr_addr <= cnt;
            y_wr_data <= s_data;
         end
      end
   end

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader on a 2x2 by 2x2 configuration with a behavioural multiplier.
// The driver queues each expected RAM write; a negedge monitor pops and compares.
module tb_matrix_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] x_wr_addr, x_wr_data, y_wr_addr, y_wr_data;
   logic        x_wr_en, y_wr_en, mm_start, mm_busy, done, err_range, active;

   matrix_loader #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .X_ROWS(2), .Y_COLS(2), .X_COLS_Y_ROWS(2), .X_MAX(255)
   ) dut (
      .clk(clk), .rst(rst), .load(load), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .x_wr_addr(x_wr_addr), .x_wr_data(x_wr_data), .x_wr_en(x_wr_en),
      .y_wr_addr(y_wr_addr), .y_wr_data(y_wr_data), .y_wr_en(y_wr_en),
      .mm_start(mm_start), .mm_busy(mm_busy), .done(done), .err_range(err_range), .active(active)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_y;
      int addr;
      int data;
      int cyc;
   } wr_t;

   wr_t exp_q[$];
   int  vectors = 0;
   int  fails = 0;
   int  cyc = 0;
   int  x_ram[4];
   int  y_ram[4];
   int  exp_z[4];
   int  busy_delay = 1;
   int  start_cnt = 0;
   int  busy_left = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Multiplier model: busy rises combinationally busy_delay cycles into start, stays high 4 cycles.
   assign mm_busy = (busy_left > 0) || (mm_start && start_cnt >= busy_delay - 1);

   always @(posedge clk) begin : mult_model
      int z;
      if (busy_left > 0) busy_left <= busy_left - 1;
      else if (mm_start && mm_busy) begin
         busy_left <= 3;
         start_cnt <= 0;
         for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
               z = x_ram[r*2] * y_ram[c] + x_ram[r*2+1] * y_ram[2+c];
               check($sformatf("Z[%0d][%0d]", r, c), z, exp_z[r*2+c]);
            end
      end else if (mm_start) start_cnt <= start_cnt + 1;
      else start_cnt <= 0;
   end

   // Monitor: every write strobe must match the head of the expected queue, including its cycle.
   always @(negedge clk) begin : monitor
      wr_t e;
      if (!rst && (x_wr_en || y_wr_en)) begin
         check("single write port", x_wr_en && y_wr_en, 0);
         if (exp_q.size() == 0) check("unexpected write", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("write to Y RAM", y_wr_en, e.is_y);
            check("write addr", y_wr_en ? y_wr_addr : x_wr_addr, e.addr);
            check("write data", y_wr_en ? y_wr_data : x_wr_data, e.data);
            check("write cycle", cyc, e.cyc);
         end
         if (x_wr_en && x_wr_addr < 4) x_ram[x_wr_addr[1:0]] = x_wr_data;
         if (y_wr_en && y_wr_addr < 4) y_ram[y_wr_addr[1:0]] = y_wr_data;
      end
   end

   task automatic check_zero(input string tag);
      check({tag, " s_ready"}, s_ready, 0);
      check({tag, " x_wr_en"}, x_wr_en, 0);
      check({tag, " x_wr_addr"}, x_wr_addr, 0);
      check({tag, " x_wr_data"}, x_wr_data, 0);
      check({tag, " y_wr_en"}, y_wr_en, 0);
      check({tag, " y_wr_addr"}, y_wr_addr, 0);
      check({tag, " y_wr_data"}, y_wr_data, 0);
      check({tag, " mm_start"}, mm_start, 0);
      check({tag, " done"}, done, 0);
      check({tag, " err_range"}, err_range, 0);
      check({tag, " active"}, active, 0);
   endtask

   // One session. stop_after>0 truncates the stream after that many beats and returns early.
   task automatic run_session(input bit clamp, input bit toggle, input bit load_mid,
                              input int delay, input int stop_after);
      int stim[8];
      int exp_d[8];
      int n, i, phase, guard, st, fall;
      bit got;
      wr_t e;
      stim  = '{clamp ? 300 : 1, 2, 3, 4, 5, 6, 7, 8};
      exp_d = '{clamp ? 255 : 1, 2, 3, 4, 5, 6, 7, 8};
      if (clamp) exp_z = '{1289, 1546, 43, 50};
      else       exp_z = '{19, 22, 43, 50};
      busy_delay = delay;
      n = (stop_after > 0) ? stop_after : 8;

      @(negedge clk) load = 1'b1;
      @(negedge clk) load = 1'b0;
      check("err_range cleared by load", err_range, 0);
      check("active in LOAD_X", active, 1);

      i = 0; phase = 0; guard = 0;
      while (i < n && guard < 100) begin
         guard++;
         load = 1'b0;
         if (toggle && phase[0]) s_valid = 1'b0;
         else begin
            s_valid = 1'b1;
            s_data  = stim[i];
            if (load_mid && i == 5) load = 1'b1;
            if (s_ready) begin
               e.is_y = (i >= 4);
               e.addr = (i >= 4) ? i - 4 : i;
               e.data = exp_d[i];
               e.cyc  = cyc + 1;
               exp_q.push_back(e);
               i++;
            end
         end
         phase++;
         @(negedge clk);
      end
      s_valid = 1'b0;
      load    = 1'b0;
      check("beats accepted", i, n);
      if (!toggle) check("stream cycles without bubbles", guard, n);
      if (stop_after > 0) return;

      st = 0; fall = -1; got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
         if (mm_start) st++;
         else if (st > 0 && !mm_busy && fall < 0) fall = c;
         if (done) begin
            got = 1'b1;
            check("done one cycle after busy low", c, fall + 1);
            check("err_range at done", err_range, clamp);
         end else @(negedge clk);
      end
      check("done seen", got, 1);
      check("mm_start cycles", st, delay);
      @(negedge clk);
      check("done single pulse", done, 0);
      check("idle after done", active, 0);
      check("err_range holds after done", err_range, clamp);
      check("write queue drained", exp_q.size(), 0);
   endtask

   initial begin
      #1 check_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_session(0, 0, 0, 1, 0);   // back-to-back stream
      run_session(0, 1, 1, 1, 0);   // valid toggling, load pulsed during LOAD_Y
      run_session(1, 0, 0, 1, 0);   // X word 300 clamped
      run_session(0, 0, 0, 1, 0);   // next load clears err_range

      run_session(0, 0, 0, 1, 3);   // abort after the 3rd X beat
      #2 rst = 1'b1;
      #1 check_zero("mid-session reset");
      check("queue empty at reset", exp_q.size(), 0);
      @(negedge clk) rst = 1'b0;
      run_session(0, 0, 0, 1, 0);   // full session after reset

      run_session(0, 0, 0, 4, 0);   // slow busy rise

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
